mcs4_addr_stack: RTL and testbench
==================================

# mcs4_addr_stack

Parametrised program-counter and return-address stack for MCS-4 family cores. It holds the PC and a DEPTH-entry circular call stack, and applies increment, jump, call and return operations. On each instruction cycle it emits the PC nibble-serially (LSB first) for the A1..A3 bus phases. It is the successor to the fixed 12-bit, 4-level address register in the i4004 core, adding configurable width and depth, selectable overflow policy and sticky error flags.

## Interface
Parameters:
- ADDR_W, 12: PC width in bits; multiple of 4, minimum 4. NIB = ADDR_W/4.
- DEPTH, 3: return-stack entries, minimum 1.
- WRAP, 1: overflow policy. 1 = overwrite oldest entry on overflow and read a stale slot on underflow. 0 = refuse the operation.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_vld  in  1  one-cycle strobe that applies op.
- op  in  2  00 INCR, 01 JUMP, 10 CALL, 11 RET.
- target  in  ADDR_W  destination for JUMP and CALL.
- cyc_start  in  1  start-of-instruction-cycle pulse (A1 phase).
- err_clr  in  1  clears ovf and unf.
- pc  out  ADDR_W  current program counter.
- addr_nib  out  4  serialised PC nibble.
- addr_vld  out  1  addr_nib valid.
- depth_used  out  $clog2(DEPTH+1)  live stack entries, 0..DEPTH.
- ovf  out  1  sticky; set by CALL when the stack is full.
- unf  out  1  sticky; set by RET when the stack is empty.

## Operation
- State:
  - pc.
  - stack[DEPTH] of ADDR_W bits.
  - wr_ptr, mod DEPTH.
  - depth_used.
  - serializer snapshot register and nibble counter.
- INCR: pc <= (pc+1) mod 2^ADDR_W. 0xFFF wraps to 0x000; no flag.
- JUMP: pc <= target. Stack untouched.
- CALL, not full:
  - stack[wr_ptr] <= pc+1 (mod 2^ADDR_W).
  - wr_ptr++ mod DEPTH; depth_used++; pc <= target.
- CALL, full (depth_used==DEPTH):
  - WRAP=1: performed as a normal CALL, overwriting the oldest entry. depth_used stays DEPTH. ovf <= 1.
  - WRAP=0: nothing changes except ovf <= 1. pc is held, not incremented.
- RET, not empty:
  - pc <= stack[(wr_ptr-1) mod DEPTH].
  - wr_ptr-- mod DEPTH; depth_used--.
- RET, empty:
  - WRAP=1: same read and wr_ptr decrement as a normal RET. depth_used stays 0. unf <= 1.
  - WRAP=0: nothing changes except unf <= 1.
- err_clr clears ovf and unf. If err_clr and a flag-setting op occur in the same cycle, set wins.
- Serializer:
  - cyc_start snapshots pc as it stands before any same-cycle op.
  - It then emits NIB nibbles, snapshot[3:0] first, one per cycle.
  - A cyc_start during emission restarts from nibble 0 with a new snapshot.
  - Ops during emission do not alter the nibbles being emitted.
- op is ignored when op_vld is low.

## Timing
- Reset is asynchronous. While rst is high, all of the following hold immediately:
  - pc, all stack entries, wr_ptr and depth_used are 0.
  - ovf and unf are 0.
  - addr_vld is 0, addr_nib is 0 and the nibble counter is idle.
- Reset asserted mid-emission aborts the emission. Emission does not resume after release.
- First edge after rst deasserts: inputs are sampled normally.
- op_vld sampled at edge N: pc, depth_used, ovf and unf reflect the op after edge N.
  - Back-to-back ops on consecutive cycles are supported, including CALL followed by RET. The RET returns the address just pushed.
- cyc_start sampled at edge N:
  - addr_vld is high for cycles N+1 .. N+NIB.
  - addr_nib carries nibble k in cycle N+1+k.
  - addr_vld drops after N+NIB unless another cyc_start arrives.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset and increment. Apply reset, then 4095 INCRs: pc=0xFFF, flags 0. One more INCR: pc=0x000, flags still 0.
- Call and return. At pc=0x010, CALL 0x123: pc=0x123, depth_used=1. Then RET: pc=0x011, depth_used=0. Then RET again: unf=1, and pc reads slot 2 (value 0, since wr_ptr wraps from 0 to 2) with WRAP=1.
- Overflow with WRAP=1, DEPTH=3. From pc=0x000, CALL 0x100, 0x200, 0x300, 0x400:
  - After the 4th CALL: ovf=1, depth_used=3, pc=0x400.
  - Three RETs give pc=0x301, then 0x201, then 0x101.
  - A 4th RET sets unf=1 and gives pc=0x301.
- Overflow with WRAP=0. Same sequence: the 4th CALL leaves pc=0x300 and depth_used=3, with ovf=1. Assert err_clr alone: ovf=0. Assert err_clr in the same cycle as another overflowing CALL: ovf stays 1.
- Serializer. With pc=0xA5C, pulse cyc_start with a same-cycle JUMP 0x777:
  - addr_nib is C, 5, A in the next 3 cycles, with addr_vld high exactly 3 cycles.
  - pc=0x777.
  - A second cyc_start in cycle 2 of the emission restarts it with 0x777's nibbles 7, 7, 7.
- Asynchronous reset mid-op. Assert rst between clock edges during emission with depth_used=2: all outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/mcs4_addr_stack.sv
// rtl/mcs4_addr_stack.sv - MCS-4 program counter, circular return stack and nibble-serial address emitter
//
// Parameters:
//   ADDR_W  PC width, multiple of 4 (NIB = ADDR_W/4 nibbles per address phase)
//   DEPTH   return-stack entries
//   WRAP    1: overflow overwrites oldest / underflow reads stale slot; 0: refuse
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   op_vld, op, target   operation strobe, 00 INCR 01 JUMP 10 CALL 11 RET, jump/call target
//   cyc_start            start of instruction cycle, snapshots pc for serial emission
//   err_clr              clears sticky ovf/unf (a same-cycle set wins)
//   pc                   current program counter
//   addr_nib, addr_vld   serial PC nibbles, LSB nibble first
//   depth_used           live stack entries 0..DEPTH
//   ovf, unf             sticky overflow / underflow flags
module mcs4_addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 3,
  parameter bit WRAP   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_vld,
  input  logic [1:0]                   op,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         cyc_start,
  input  logic                         err_clr,
  output logic [ADDR_W-1:0]            pc,
  output logic [3:0]                   addr_nib,
  output logic                         addr_vld,
  output logic [$clog2(DEPTH+1)-1:0]   depth_used,
  output logic                         ovf,
  output logic                         unf
);

  localparam int NIB = ADDR_W / 4;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DUW = $clog2(DEPTH + 1);
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] OP_INCR = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic [ADDR_W-1:0] stack [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     ptr_inc;
  logic [PW-1:0]     ptr_dec;
  logic [ADDR_W-1:0] pc_inc;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] snap;
  logic [CW-1:0]     left;

  assign ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign ptr_dec = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
  assign pc_inc  = pc + ADDR_W'(1);
  assign full    = (depth_used == DUW'(DEPTH));
  assign empty   = (depth_used == '0);

  // Program counter, return stack and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      wr_ptr     <= '0;
      depth_used <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      // Clear first so that a flag set by the op below takes priority.
      if (err_clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (op_vld) begin
        case (op)
          OP_INCR: pc <= pc_inc;
          OP_JUMP: pc <= target;
          OP_CALL: begin
            if (full) ovf <= 1'b1;
            if (!full || WRAP) begin
              stack[wr_ptr] <= pc_inc;
              wr_ptr        <= ptr_inc;
              pc            <= target;
              if (!full) depth_used <= depth_used + DUW'(1);
            end
          end
          OP_RET: begin
            if (empty) unf <= 1'b1;
            if (!empty || WRAP) begin
              pc     <= stack[ptr_dec];
              wr_ptr <= ptr_dec;
              if (!empty) depth_used <= depth_used - DUW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Serializer: snap holds the not-yet-emitted upper nibbles, shifted down
  // one nibble per cycle; left counts nibbles still to come after addr_nib.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap     <= '0;
      left     <= '0;
      addr_nib <= 4'h0;
      addr_vld <= 1'b0;
    end else if (cyc_start) begin
      addr_nib <= pc[3:0];
      snap     <= pc >> 4;
      left     <= CW'(NIB - 1);
      addr_vld <= 1'b1;
    end else if (addr_vld) begin
      if (left == '0) begin
        addr_vld <= 1'b0;
        addr_nib <= 4'h0;
      end else begin
        addr_nib <= snap[3:0];
        snap     <= snap >> 4;
        left     <= left - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mcs4_addr_stack.sv
// tb/tb_mcs4_addr_stack.sv - scoreboard bench for mcs4_addr_stack, WRAP=1 and WRAP=0 instances
module tb_mcs4_addr_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_vld = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [11:0] target = 12'h000;
  logic        cyc_start = 1'b0;
  logic        err_clr = 1'b0;

  logic [11:0] pc_o [2];
  logic [3:0]  nib_o [2];
  logic        vld_o [2];
  logic [1:0]  du_o [2];
  logic        ovf_o [2];
  logic        unf_o [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcs4_addr_stack #(.ADDR_W(12), .DEPTH(3), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .op_vld(op_vld), .op(op), .target(target),
    .cyc_start(cyc_start), .err_clr(err_clr), .pc(pc_o[0]), .addr_nib(nib_o[0]),
    .addr_vld(vld_o[0]), .depth_used(du_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0])
  );

  mcs4_addr_stack #(.ADDR_W(12), .DEPTH(3), .WRAP(1'b0)) dut_hold (
    .clk(clk), .rst(rst), .op_vld(op_vld), .op(op), .target(target),
    .cyc_start(cyc_start), .err_clr(err_clr), .pc(pc_o[1]), .addr_nib(nib_o[1]),
    .addr_vld(vld_o[1]), .depth_used(du_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model, index 0 = WRAP=1 instance, 1 = WRAP=0 instance.
  logic [11:0] m_pc [2];
  logic [11:0] m_stk [2][3];
  int          m_wp [2];
  int          m_du [2];
  logic        m_ovf [2];
  logic        m_unf [2];

  typedef struct {
    logic [11:0] pc;
    int          du;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        exp_q [$];
  logic [3:0]  nib_q [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 12'h000; m_wp[d] = 0; m_du[d] = 0; m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
      for (int i = 0; i < 3; i++) m_stk[d][i] = 12'h000;
    end
  endtask

  task automatic model_op(input int d, input logic v, input logic [1:0] o,
                          input logic [11:0] t, input logic ec);
    bit wrap;
    wrap = (d == 0);
    if (ec) begin m_ovf[d] = 1'b0; m_unf[d] = 1'b0; end
    if (v) begin
      case (o)
        2'b00: m_pc[d] = m_pc[d] + 12'h001;
        2'b01: m_pc[d] = t;
        2'b10: begin
          if (m_du[d] == 3) m_ovf[d] = 1'b1;
          if (m_du[d] < 3 || wrap) begin
            m_stk[d][m_wp[d]] = m_pc[d] + 12'h001;
            m_wp[d] = (m_wp[d] + 1) % 3;
            if (m_du[d] < 3) m_du[d]++;
            m_pc[d] = t;
          end
        end
        default: begin
          if (m_du[d] == 0) m_unf[d] = 1'b1;
          if (m_du[d] > 0 || wrap) begin
            m_wp[d] = (m_wp[d] + 2) % 3;
            m_pc[d] = m_stk[d][m_wp[d]];
            if (m_du[d] > 0) m_du[d]--;
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of stimulus, push expectations, then compare after the edge.
  task automatic step(input logic v, input logic [1:0] o, input logic [11:0] t,
                      input logic ec, input logic cs);
    logic [11:0] snap;
    exp_t e;
    op_vld = v; op = o; target = t; err_clr = ec; cyc_start = cs;
    snap = m_pc[0];
    for (int d = 0; d < 2; d++) begin
      model_op(d, v, o, t, ec);
      e.pc = m_pc[d]; e.du = m_du[d]; e.ovf = m_ovf[d]; e.unf = m_unf[d];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    op_vld = 1'b0; err_clr = 1'b0; cyc_start = 1'b0;
    if (cs) begin
      nib_q.delete();
      for (int k = 0; k < 3; k++) nib_q.push_back(4'((snap >> (4 * k)) & 12'h00F));
    end
    for (int d = 0; d < 2; d++) begin
      e = exp_q.pop_front();
      check($sformatf("pc%0d", d), 32'(pc_o[d]), 32'(e.pc));
      check($sformatf("du%0d", d), 32'(du_o[d]), 32'(e.du));
      check($sformatf("ovf%0d", d), 32'(ovf_o[d]), 32'(e.ovf));
      check($sformatf("unf%0d", d), 32'(unf_o[d]), 32'(e.unf));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_pc"}, 32'(pc_o[d]), 32'h0);
      check({tag, "_nib"}, 32'(nib_o[d]), 32'h0);
      check({tag, "_vld"}, 32'(vld_o[d]), 32'h0);
      check({tag, "_du"}, 32'(du_o[d]), 32'h0);
      check({tag, "_ovf"}, 32'(ovf_o[d]), 32'h0);
      check({tag, "_unf"}, 32'(unf_o[d]), 32'h0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    nib_q.delete();
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Nibble monitor on the WRAP=1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld_o[0]) begin
        if (nib_q.size() == 0) check("vld_extra", 32'(vld_o[0]), 32'h0);
        else check("nib", 32'(nib_o[0]), 32'(nib_q.pop_front()));
      end else if (nib_q.size() != 0) begin
        check("vld_missing", 32'(vld_o[0]), 32'h1);
        nib_q.delete();
      end
    end
  end

  initial begin
    model_reset();
    #3;
    check_zero("rst");
    @(posedge clk);
    #2 rst = 1'b0;

    // Increment across the full address range.
    for (int i = 0; i < 4095; i++) step(1'b1, 2'b00, 12'h000, 1'b0, 1'b0);
    check("inc_fff", 32'(pc_o[0]), 32'hFFF);
    step(1'b1, 2'b00, 12'h000, 1'b0, 1'b0);
    check("inc_wrap", 32'(pc_o[0]), 32'h000);
    check("inc_wrap_ovf", 32'(ovf_o[0]), 32'h0);

    // Call / return / underflow.
    step(1'b1, 2'b01, 12'h010, 1'b0, 1'b0);
    step(1'b1, 2'b10, 12'h123, 1'b0, 1'b0);
    check("call_pc", 32'(pc_o[0]), 32'h123);
    step(1'b1, 2'b11, 12'h000, 1'b0, 1'b0);
    check("ret_pc", 32'(pc_o[0]), 32'h011);
    step(1'b1, 2'b11, 12'h000, 1'b0, 1'b0);
    check("unf_wrap_pc", 32'(pc_o[0]), 32'h000);
    check("unf_wrap", 32'(unf_o[0]), 32'h1);
    check("unf_hold_pc", 32'(pc_o[1]), 32'h011);
    step(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);

    // Overflow sequence on both policies.
    do_reset();
    step(1'b1, 2'b10, 12'h100, 1'b0, 1'b0);
    step(1'b1, 2'b10, 12'h200, 1'b0, 1'b0);
    step(1'b1, 2'b10, 12'h300, 1'b0, 1'b0);
    step(1'b1, 2'b10, 12'h400, 1'b0, 1'b0);
    check("ovf_wrap_pc", 32'(pc_o[0]), 32'h400);
    check("ovf_hold_pc", 32'(pc_o[1]), 32'h300);
    check("ovf_hold", 32'(ovf_o[1]), 32'h1);
    step(1'b1, 2'b11, 12'h000, 1'b0, 1'b0);
    check("ret1", 32'(pc_o[0]), 32'h301);
    step(1'b1, 2'b11, 12'h000, 1'b0, 1'b0);
    check("ret2", 32'(pc_o[0]), 32'h201);
    step(1'b1, 2'b11, 12'h000, 1'b0, 1'b0);
    check("ret3", 32'(pc_o[0]), 32'h101);
    step(1'b1, 2'b11, 12'h000, 1'b0, 1'b0);
    check("ret4", 32'(pc_o[0]), 32'h301);
    step(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
    check("err_clr", 32'(ovf_o[1]), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 12'h050 + 12'(i), 1'b0, 1'b0);
    step(1'b1, 2'b10, 12'h060, 1'b1, 1'b0);
    check("set_wins", 32'(ovf_o[1]), 32'h1);
    // Back-to-back call then return.
    step(1'b1, 2'b10, 12'h3AB, 1'b0, 1'b0);
    step(1'b1, 2'b11, 12'h000, 1'b0, 1'b0);

    // Serializer with same-cycle jump, then restart mid-emission.
    step(1'b1, 2'b01, 12'hA5C, 1'b0, 1'b0);
    step(1'b1, 2'b01, 12'h777, 1'b0, 1'b1);
    idle(4);
    step(1'b0, 2'b00, 12'h000, 1'b0, 1'b1);
    step(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
    step(1'b1, 2'b01, 12'h9B2, 1'b0, 1'b1);
    step(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
    step(1'b0, 2'b00, 12'h000, 1'b0, 1'b1);
    idle(4);

    // Asynchronous reset during emission with two live entries.
    do_reset();
    step(1'b1, 2'b10, 12'h111, 1'b0, 1'b0);
    step(1'b1, 2'b10, 12'h222, 1'b0, 1'b0);
    check("pre_rst_du", 32'(du_o[0]), 32'h2);
    step(1'b0, 2'b00, 12'h000, 1'b0, 1'b1);
    #1 rst = 1'b1;
    nib_q.delete();
    model_reset();
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
